aes_round_ops: RTL and testbench



---
 rtl/aes_pkg.sv | 85 ++++++++
 rtl/aes_mix_column.sv | 11 +
 rtl/aes_round_ops.sv | 132 +++++++++++++
 tb/tb_aes_round_ops.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, round-type encodings and GF(2^8) helpers for the AES round datapath.
// Inverse-cipher helpers are compiled only when AES_INV_EN is defined.
package aes_pkg;

   typedef logic [127:0] aes_state_t;

   localparam logic [1:0] RT_INIT  = 2'd0;
   localparam logic [1:0] RT_MID   = 2'd1;
   localparam logic [1:0] RT_FINAL = 2'd2;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Byte k lives at [127-8k -: 8]; row = k%4, column = k/4.
   function automatic aes_state_t shift_rows(input aes_state_t s);
      aes_state_t o;
      o = 128'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

`ifdef AES_INV_EN
   function automatic aes_state_t inv_shift_rows(input aes_state_t s);
      aes_state_t o;
      o = 128'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   function automatic aes_state_t inv_mix_state(input aes_state_t s);
      aes_state_t o;
      o = 128'd0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
      end
      return o;
   endfunction
`endif

endpackage

// File: rtl/aes_mix_column.sv
// Combinational AES MixColumns transform of one 32-bit column (row 0 in the top byte).
module aes_mix_column
   import aes_pkg::*;
(
   input  logic [31:0] i_col,
   output logic [31:0] o_col
);

   assign o_col = mix_column(i_col);

endmodule

// File: rtl/aes_round_ops.sv
// Three-stage registered AES-128 round: ShiftRows -> MixColumns -> AddRoundKey.
// Define AES_INV_EN to add the decrypt port (InvShiftRows -> AddRoundKey -> InvMixColumns).
module aes_round_ops
   import aes_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [1:0]   round_type,
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
`ifdef AES_INV_EN
   input  logic         decrypt,
`endif
   output logic [127:0] state_out,
   output logic         done
);

   logic [LATENCY-1:0] r_vld;
   aes_state_t         r_s1_state;
   aes_state_t         r_s1_key;
   logic [1:0]         r_s1_type;
   aes_state_t         r_s2_state;
   aes_state_t         r_s2_key;
   aes_state_t         r_out;
`ifdef AES_INV_EN
   logic               r_s1_dec;
   logic               r_s2_dec;
   logic [1:0]         r_s2_type;
`endif

   aes_state_t w_s1_state;
   aes_state_t w_mix;
   aes_state_t w_s2_enc;
   aes_state_t w_s2_state;
   aes_state_t w_s3_state;

   // Stage 1 row permutation; the initial round passes the plaintext straight through.
   always_comb begin
      w_s1_state = state_in;
      case (round_type)
         RT_INIT: w_s1_state = state_in;
`ifdef AES_INV_EN
         default: w_s1_state = decrypt ? inv_shift_rows(state_in) : shift_rows(state_in);
`else
         default: w_s1_state = shift_rows(state_in);
`endif
      endcase
   end

   for (genvar g = 0; g < 4; g++) begin : g_mix
      aes_mix_column u_mix (
         .i_col (r_s1_state[127-32*g -: 32]),
         .o_col (w_mix[127-32*g -: 32])
      );
   end

   // Stage 2 column mixing; reserved round type behaves as a middle round.
   always_comb begin
      w_s2_enc = r_s1_state;
      case (r_s1_type)
         RT_INIT, RT_FINAL: w_s2_enc = r_s1_state;
         RT_MID:            w_s2_enc = w_mix;
         default:           w_s2_enc = w_mix;
      endcase
   end

`ifdef AES_INV_EN
   assign w_s2_state = r_s1_dec ? (r_s1_state ^ r_s1_key) : w_s2_enc;

   // Stage 3: key add for encryption, inverse column mixing for middle decrypt rounds.
   always_comb begin
      w_s3_state = r_s2_state ^ r_s2_key;
      if (r_s2_dec) begin
         case (r_s2_type)
            RT_INIT, RT_FINAL: w_s3_state = r_s2_state;
            default:           w_s3_state = inv_mix_state(r_s2_state);
         endcase
      end else begin
         w_s3_state = r_s2_state ^ r_s2_key;
      end
   end
`else
   assign w_s2_state = w_s2_enc;
   assign w_s3_state = r_s2_state ^ r_s2_key;
`endif

   // Pipeline registers; key and round type ride along so every stage costs one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld      <= '0;
         r_s1_state <= 128'd0;
         r_s1_key   <= 128'd0;
         r_s1_type  <= 2'd0;
         r_s2_state <= 128'd0;
         r_s2_key   <= 128'd0;
         r_out      <= 128'd0;
`ifdef AES_INV_EN
         r_s1_dec   <= 1'b0;
         r_s2_dec   <= 1'b0;
         r_s2_type  <= 2'd0;
`endif
      end else begin
         r_vld <= {r_vld[LATENCY-2:0], enable};
         if (enable) begin
            r_s1_state <= w_s1_state;
            r_s1_key   <= round_key;
            r_s1_type  <= round_type;
`ifdef AES_INV_EN
            r_s1_dec   <= decrypt;
`endif
         end
         if (r_vld[0]) begin
            r_s2_state <= w_s2_state;
            r_s2_key   <= r_s1_key;
`ifdef AES_INV_EN
            r_s2_dec   <= r_s1_dec;
            r_s2_type  <= r_s1_type;
`endif
         end
         if (r_vld[1]) begin
            r_out <= w_s3_state;
         end
      end
   end

   assign state_out = r_out;
   assign done      = r_vld[LATENCY-1];

endmodule

// File: tb/tb_aes_round_ops.sv
// Directed-vector bench for aes_round_ops: table of hand-computed rounds plus streaming/reset sequences.
module tb_aes_round_ops;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [1:0]   round_type;
   logic [127:0] state_in;
   logic [127:0] round_key;
   logic [127:0] state_out;
   logic         done;
`ifdef AES_INV_EN
   logic         decrypt;
`endif

   always #5 clk = ~clk;

   aes_round_ops dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .round_type (round_type),
      .state_in   (state_in),
      .round_key  (round_key),
`ifdef AES_INV_EN
      .decrypt    (decrypt),
`endif
      .state_out  (state_out),
      .done       (done)
   );

   typedef struct {
      string        name;
      logic [1:0]   rt;
      logic         dec;
      logic [127:0] st;
      logic [127:0] key;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input string name, input logic [1:0] rt, input logic dec,
                               input logic [127:0] st, input logic [127:0] key,
                               input logic [127:0] exp);
      vec_t v;
      v.name = name;
      v.rt   = rt;
      v.dec  = dec;
      v.st   = st;
      v.key  = key;
      v.exp  = exp;
      return v;
   endfunction

   // Called at a negedge; presents one beat and returns at the next negedge.
   task automatic drive(input vec_t v);
      enable     = 1'b1;
      round_type = v.rt;
      state_in   = v.st;
      round_key  = v.key;
`ifdef AES_INV_EN
      decrypt    = v.dec;
`endif
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      lat = 0;
      drive(v);
      for (int i = 1; i <= 6; i++) begin
         if (done === 1'b1) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      chk({v.name, " latency"}, 128'(lat), 128'd3);
      chk({v.name, " data"}, state_out, v.exp);
      @(negedge clk);
      chk({v.name, " done pulse width"}, {127'd0, done}, 128'd0);
      chk({v.name, " hold"}, state_out, v.exp);
   endtask

   task automatic check_quiet(input string name);
      int seen;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (done !== 1'b0) seen++;
      end
      chk({name, " no done"}, 128'(seen), 128'd0);
      chk({name, " state_out cleared"}, state_out, 128'd0);
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      round_type = 2'd0;
      state_in   = 128'd0;
      round_key  = 128'd0;
`ifdef AES_INV_EN
      decrypt    = 1'b0;
`endif

      vecs.push_back(mk("init_fips", 2'd0, 1'b0, 128'h3243f6a8885a308d313198a2e0370734,
                        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h193de3bea0f4e22b9ac68d2ae9f84808));
      vecs.push_back(mk("mid_fips", 2'd1, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230,
                        128'ha0fafe1788542cb123a339392a6c7605, 128'ha49c7ff2689f352b6b5bea43026a5049));
      vecs.push_back(mk("final_shift", 2'd2, 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                        128'd0, 128'h00050a0f04090e03080d02070c01060b));
      vecs.push_back(mk("final_key_ff", 2'd2, 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                        {128{1'b1}}, 128'hfffaf5f0fbf6f1fcf7f2fdf8f3fef9f4));
      vecs.push_back(mk("mix_db135345", 2'd1, 1'b0, {4{32'hdb135345}}, 128'd0, {4{32'h8e4da1bc}}));
      vecs.push_back(mk("reserved_as_mid", 2'd3, 1'b0, {4{32'hdb135345}}, 128'd0, {4{32'h8e4da1bc}}));
      vecs.push_back(mk("mix_f20a225c", 2'd1, 1'b0, {4{32'hf20a225c}}, 128'd0, {4{32'h9fdc589d}}));
`ifdef AES_INV_EN
      vecs.push_back(mk("dec_inv_shift", 2'd2, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                        128'd0, 128'h000d0a0704010e0b0805020f0c090603));
      vecs.push_back(mk("dec_inv_mix", 2'd1, 1'b1, {4{32'h8e4da1bc}}, 128'd0, {4{32'hdb135345}}));
      vecs.push_back(mk("dec_init", 2'd0, 1'b1, 128'h3243f6a8885a308d313198a2e0370734,
                        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h193de3bea0f4e22b9ac68d2ae9f84808));
`endif
      vecs.push_back(mk("init_identity", 2'd0, 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                        128'd0, 128'h000102030405060708090a0b0c0d0e0f));

      repeat (3) @(negedge clk);
      chk("reset done", {127'd0, done}, 128'd0);
      chk("reset state_out", state_out, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Three back-to-back beats must emerge on three consecutive cycles, in order.
      drive(vecs[1]);
      drive(vecs[2]);
      drive(vecs[4]);
      chk("stream beat0 done", {127'd0, done}, 128'd1);
      chk("stream beat0 data", state_out, vecs[1].exp);
      @(negedge clk);
      chk("stream beat1 done", {127'd0, done}, 128'd1);
      chk("stream beat1 data", state_out, vecs[2].exp);
      @(negedge clk);
      chk("stream beat2 done", {127'd0, done}, 128'd1);
      chk("stream beat2 data", state_out, vecs[4].exp);
      @(negedge clk);
      chk("stream idle done", {127'd0, done}, 128'd0);
      chk("stream idle hold", state_out, vecs[4].exp);

      // Reset one cycle after an enable discards the in-flight beat.
      drive(vecs[1]);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_quiet("rst_midflight");

      // Reset and enable together: reset wins.
      run_vec(vecs[0]);
      rst = 1'b1;
      drive(vecs[1]);
      rst = 1'b0;
      check_quiet("rst_with_enable");

      run_vec(vecs[1]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
